// File: rtl/alphamission_vram_arbiter.sv
// ---------------------------------------------------------------------------
// alphamission_vram_arbiter
//
// Time-slot arbiter for the shared video bus (VA, VD, layer chip selects,
// V/C selector and the VWE/VOE/VDG strobes). CPU A and CPU B get access
// windows only at two fixed H[2:0] phases of the pixel enable; all other
// phases belong to the layer video fetch. One CPU is granted per window
// (round-robin on contention) and the access runs SETUP -> STROBE -> DONE.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   cen                   pixel clock enable; state advances only on cen,
//                         except DONE -> IDLE which takes a single clk
//   h_phase               H[2:0] from video timing
//   a_*/b_*               CPU request channels (req held until ack; we,
//                         addr, wdata, sel target 00 side/01 back1/
//                         10 front/11 none); ack is a one-clk pulse;
//                         rdata holds the last read result of that CPU
//   vram_rdata            muxed layer read bus (8'hFF when nothing selected)
//   VA, VD_in             bus address / write data to the layers
//   *_CSn                 active-low layer chip selects
//   V_C                   1 = CPU owns the SRAM address, 0 = video
//   VWE, VOE, VDG         active-low write strobe, output enable, read gate
//   owner                 debug: 00 none, 01 A, 10 B
// ---------------------------------------------------------------------------
module alphamission_vram_arbiter #(
   parameter logic [2:0] SLOT_A = 3'd3,
   parameter logic [2:0] SLOT_B = 3'd7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cen,
   input  logic [2:0]  h_phase,
   input  logic        a_req,
   input  logic        b_req,
   input  logic        a_we,
   input  logic        b_we,
   input  logic [11:0] a_addr,
   input  logic [11:0] b_addr,
   input  logic [7:0]  a_wdata,
   input  logic [7:0]  b_wdata,
   input  logic [1:0]  a_sel,
   input  logic [1:0]  b_sel,
   output logic        a_ack,
   output logic        b_ack,
   output logic [7:0]  a_rdata,
   output logic [7:0]  b_rdata,
   input  logic [7:0]  vram_rdata,
   output logic [11:0] VA,
   output logic [7:0]  VD_in,
   output logic        SIDE_VRAM_CSn,
   output logic        BACK1_VRAM_CSn,
   output logic        FRONT_VIDEO_CSn,
   output logic        V_C,
   output logic        VWE,
   output logic        VOE,
   output logic        VDG,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

   state_t      state, state_nx;
   logic        last_b;     // 1 = last grant went to B
   logic        own_b;      // owner of the access in flight
   logic        lat_we;
   logic [11:0] lat_addr;
   logic [7:0]  lat_wdata;
   logic [1:0]  lat_sel;

   logic        window;
   logic        take;
   logic        grant_b;
   logic        bus_act;
   logic        rd_close;

   assign window   = cen && ((h_phase == SLOT_A) || (h_phase == SLOT_B));
   assign take     = (state == IDLE) && window && (a_req || b_req);
   // B wins when alone, or on a tie when A was served last.
   assign grant_b  = b_req && (!a_req || !last_b);
   assign rd_close = (state == STROBE) && cen && !lat_we;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (take) state_nx = SETUP;
         SETUP:   if (cen)  state_nx = STROBE;
         STROBE:  if (cen)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         last_b  <= 1'b1;
         own_b   <= 1'b0;
         a_rdata <= 8'hFF;
         b_rdata <= 8'hFF;
      end else begin
         state <= state_nx;
         if (take) begin
            own_b  <= grant_b;
            last_b <= grant_b;
         end
         // The "none" target has no driver on the layer bus, so it reads FF.
         if (rd_close) begin
            if (own_b) b_rdata <= (lat_sel == 2'b11) ? 8'hFF : vram_rdata;
            else       a_rdata <= (lat_sel == 2'b11) ? 8'hFF : vram_rdata;
         end
      end
   end

   // Request fields are only observed while the bus is active, so they
   // need no reset.
   always_ff @(posedge clk) begin
      if (take) begin
         lat_we    <= grant_b ? b_we    : a_we;
         lat_addr  <= grant_b ? b_addr  : a_addr;
         lat_wdata <= grant_b ? b_wdata : a_wdata;
         lat_sel   <= grant_b ? b_sel   : a_sel;
      end
   end

   // Bus outputs decode straight from the registered state so reset clears
   // them without waiting for a clock edge.
   assign bus_act         = (state == SETUP) || (state == STROBE);
   assign V_C             = bus_act;
   assign VA              = bus_act ? lat_addr : 12'h000;
   assign VD_in           = (bus_act && lat_we) ? lat_wdata : 8'h00;
   assign SIDE_VRAM_CSn   = !(bus_act && (lat_sel == 2'b00));
   assign BACK1_VRAM_CSn  = !(bus_act && (lat_sel == 2'b01));
   assign FRONT_VIDEO_CSn = !(bus_act && (lat_sel == 2'b10));
   assign VWE             = !((state == STROBE) && lat_we);
   assign VOE             = !((state == STROBE) && !lat_we);
   assign VDG             = !((state == STROBE) && !lat_we);
   assign owner           = bus_act ? (own_b ? 2'b10 : 2'b01) : 2'b00;
   assign a_ack           = (state == DONE) && !own_b;
   assign b_ack           = (state == DONE) && own_b;

endmodule

// File: tb/tb_alphamission_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alphamission_vram_arbiter
//
// Bench for the video bus arbiter. A free-running divider makes cen every
// 8 clks and advances h_phase on each cen. A small layer model stores
// writes and returns stored (or seeded) bytes on reads. Reference state
// (last grant, expected memory contents) is kept in plain variables.
// ---------------------------------------------------------------------------
module tb_alphamission_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  div = 3'd0;
   logic        cen;
   logic [2:0]  h_phase = 3'd0;
   logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
   logic [11:0] a_addr = 12'h0, b_addr = 12'h0;
   logic [7:0]  a_wdata = 8'h0, b_wdata = 8'h0;
   logic [1:0]  a_sel = 2'b00, b_sel = 2'b00;
   logic        a_ack, b_ack;
   logic [7:0]  a_rdata, b_rdata, vram_rdata;
   logic [11:0] VA;
   logic [7:0]  VD_in;
   logic        SIDE_VRAM_CSn, BACK1_VRAM_CSn, FRONT_VIDEO_CSn;
   logic        V_C, VWE, VOE, VDG;
   logic [1:0]  owner;

   int total = 0;
   int bad = 0;
   int inv_viol = 0;
   bit ref_last_b = 1'b1;

   logic       rd_ovr_en = 1'b0;
   logic [7:0] rd_ovr = 8'h00;

   logic [7:0] lmem [3][4096];
   bit         lwr  [3][4096];
   logic [7:0] ref_mem [3][4096];
   bit         ref_wr  [3][4096];

   typedef struct {
      int side, back, front, vwe, voe, vdg, vc;
      int a_ack, b_ack, a_ack_at, b_ack_at, bus_first, strobe_first;
      logic [2:0]  bus_phase;
      logic [11:0] va_seen;
      logic [7:0]  vd_seen;
      logic [1:0]  own_seen;
   } obs_t;

   alphamission_vram_arbiter dut (
      .clk(clk), .reset(reset), .cen(cen), .h_phase(h_phase),
      .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
      .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
      .a_sel(a_sel), .b_sel(b_sel), .a_ack(a_ack), .b_ack(b_ack),
      .a_rdata(a_rdata), .b_rdata(b_rdata), .vram_rdata(vram_rdata),
      .VA(VA), .VD_in(VD_in), .SIDE_VRAM_CSn(SIDE_VRAM_CSn),
      .BACK1_VRAM_CSn(BACK1_VRAM_CSn), .FRONT_VIDEO_CSn(FRONT_VIDEO_CSn),
      .V_C(V_C), .VWE(VWE), .VOE(VOE), .VDG(VDG), .owner(owner)
   );

   always #5 clk = ~clk;

   assign cen = (div == 3'd7);
   always @(posedge clk) begin
      div <= div + 3'd1;
      if (cen) h_phase <= h_phase + 3'd1;
   end

   function automatic logic [7:0] seed_byte(input int l, input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'(l * 53) ^ 8'h96;
   endfunction

   // Layer SRAM model
   always @(posedge clk) begin
      if (!VWE) begin
         if (!SIDE_VRAM_CSn)   begin lmem[0][VA] <= VD_in; lwr[0][VA] <= 1'b1; end
         if (!BACK1_VRAM_CSn)  begin lmem[1][VA] <= VD_in; lwr[1][VA] <= 1'b1; end
         if (!FRONT_VIDEO_CSn) begin lmem[2][VA] <= VD_in; lwr[2][VA] <= 1'b1; end
      end
   end

   always_comb begin
      vram_rdata = 8'hFF;
      if (!VOE) begin
         if (rd_ovr_en)             vram_rdata = rd_ovr;
         else if (!SIDE_VRAM_CSn)   vram_rdata = lwr[0][VA] ? lmem[0][VA] : seed_byte(0, VA);
         else if (!BACK1_VRAM_CSn)  vram_rdata = lwr[1][VA] ? lmem[1][VA] : seed_byte(1, VA);
         else if (!FRONT_VIDEO_CSn) vram_rdata = lwr[2][VA] ? lmem[2][VA] : seed_byte(2, VA);
      end
   end

   // Bus-safety watch: single CSn, no write/read strobe overlap, strobes only under V_C.
   always @(negedge clk) begin
      if ((int'(!SIDE_VRAM_CSn) + int'(!BACK1_VRAM_CSn) + int'(!FRONT_VIDEO_CSn)) > 1 ||
          (!VWE && !VOE) || ((!VWE || !VOE || !VDG) && !V_C) || (a_ack && b_ack))
         inv_viol++;
   end

   function automatic logic [46:0] outs();
      return {SIDE_VRAM_CSn, BACK1_VRAM_CSn, FRONT_VIDEO_CSn, VWE, VOE, VDG, V_C,
              VA, VD_in, a_ack, b_ack, a_rdata, b_rdata, owner};
   endfunction

   function automatic logic [7:0] ref_read(input logic [1:0] s, input logic [11:0] a);
      if (s == 2'b11) return 8'hFF;
      return ref_wr[s][a] ? ref_mem[s][a] : seed_byte(int'(s), a);
   endfunction

   task automatic wait_window(input logic [2:0] p, input bit any);
      int k = 0;
      bit hit = 1'b0;
      while (!hit && k < 200) begin
         @(negedge clk);
         k++;
         hit = cen && (any ? (h_phase == 3'd3 || h_phase == 3'd7) : (h_phase == p));
      end
      if (!hit) begin
         total++; bad++;
         $display("FAIL window_timeout got_phase=%0d want_phase=%0d", h_phase, p);
      end
   endtask

   task automatic observe(input int n, input bit drop, output obs_t o);
      o = '{default: 0};
      o.bus_first = -1; o.strobe_first = -1; o.a_ack_at = -1; o.b_ack_at = -1;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (!SIDE_VRAM_CSn)   o.side++;
         if (!BACK1_VRAM_CSn)  o.back++;
         if (!FRONT_VIDEO_CSn) o.front++;
         if (!VWE) o.vwe++;
         if (!VOE) o.voe++;
         if (!VDG) o.vdg++;
         if ((!VWE || !VOE) && o.strobe_first < 0) o.strobe_first = i;
         if (V_C) begin
            o.vc++;
            if (o.bus_first < 0) begin o.bus_first = i; o.bus_phase = h_phase; end
            o.va_seen = VA; o.vd_seen = VD_in; o.own_seen = owner;
         end
         if (a_ack) begin o.a_ack++; o.a_ack_at = i; if (drop) a_req = 1'b0; end
         if (b_ack) begin o.b_ack++; o.b_ack_at = i; if (drop) b_req = 1'b0; end
      end
   endtask

   task automatic test_reset();
      logic [46:0] exp_r = {7'b1111110, 12'h000, 8'h00, 2'b00, 8'hFF, 8'hFF, 2'b00};
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (outs() !== exp_r) begin bad++; $display("FAIL reset_outs got=%h exp=%h", outs(), exp_r); end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (outs() !== exp_r) begin bad++; $display("FAIL idle_outs got=%h exp=%h", outs(), exp_r); end
      ref_last_b = 1'b1;
   endtask

   task automatic test_tie();
      obs_t o;
      bit eb;
      wait_window(3'd3, 1'b0);
      a_req = 1; a_we = 1; a_sel = 2'b00; a_addr = 12'h010; a_wdata = 8'h11;
      b_req = 1; b_we = 1; b_sel = 2'b00; b_addr = 12'h020; b_wdata = 8'h22;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) wait_window((k % 2 == 1) ? 3'd7 : 3'd3, 1'b0);
         eb = !ref_last_b;
         observe(20, 1'b0, o);
         total++;
         if (o.own_seen !== (eb ? 2'b10 : 2'b01)) begin bad++; $display("FAIL tie_owner k=%0d got=%0d exp=%0d", k, o.own_seen, eb ? 2 : 1); end
         total++;
         if ((eb ? {o.b_ack, o.b_ack_at, o.a_ack} : {o.a_ack, o.a_ack_at, o.b_ack}) !== {32'd1, 32'd17, 32'd0}) begin
            bad++; $display("FAIL tie_ack k=%0d a=%0d@%0d b=%0d@%0d exp_one_at_17", k, o.a_ack, o.a_ack_at, o.b_ack, o.b_ack_at);
         end
         total++;
         if (o.vd_seen !== (eb ? 8'h22 : 8'h11)) begin bad++; $display("FAIL tie_vd k=%0d got=%h exp=%h", k, o.vd_seen, eb ? 8'h22 : 8'h11); end
         total++;
         if (o.va_seen !== (eb ? 12'h020 : 12'h010)) begin bad++; $display("FAIL tie_va k=%0d got=%h", k, o.va_seen); end
         ref_last_b = eb;
      end
      a_req = 0; b_req = 0;
      ref_mem[0][12'h010] = 8'h11; ref_wr[0][12'h010] = 1;
      ref_mem[0][12'h020] = 8'h22; ref_wr[0][12'h020] = 1;
   endtask

   task automatic test_read_back1();
      obs_t o;
      wait_window(3'd3, 1'b0);
      rd_ovr_en = 1; rd_ovr = 8'h5A;
      a_req = 1; a_we = 0; a_sel = 2'b01; a_addr = 12'h234;
      observe(24, 1'b1, o);
      rd_ovr_en = 0;
      total++;
      if ({o.back, o.side, o.front, o.bus_first} !== {32'd16, 32'd0, 32'd0, 32'd1}) begin
         bad++; $display("FAIL rd_cs back=%0d side=%0d front=%0d first=%0d exp=16/0/0/1", o.back, o.side, o.front, o.bus_first);
      end
      total++;
      if ({o.voe, o.vdg, o.vwe, o.strobe_first} !== {32'd8, 32'd8, 32'd0, 32'd9}) begin
         bad++; $display("FAIL rd_strobe voe=%0d vdg=%0d vwe=%0d first=%0d exp=8/8/0/9", o.voe, o.vdg, o.vwe, o.strobe_first);
      end
      total++;
      if ({o.a_ack, o.a_ack_at, o.b_ack} !== {32'd1, 32'd17, 32'd0}) begin
         bad++; $display("FAIL rd_ack a=%0d@%0d b=%0d exp=1@17/0", o.a_ack, o.a_ack_at, o.b_ack);
      end
      total++;
      if (a_rdata !== 8'h5A || o.va_seen !== 12'h234) begin bad++; $display("FAIL rd_data got=%h va=%h exp=5a/234", a_rdata, o.va_seen); end
      ref_last_b = 0;
   endtask

   task automatic test_off_window();
      obs_t o;
      wait_window(3'd4, 1'b0);
      b_req = 1; b_we = 0; b_sel = 2'b00; b_addr = 12'h050;
      observe(44, 1'b1, o);
      total++;
      if (o.bus_first !== 25 || o.bus_phase !== 3'd0) begin
         bad++; $display("FAIL offwin_start got=%0d phase=%0d exp=25/0", o.bus_first, o.bus_phase);
      end
      total++;
      if ({o.b_ack, o.b_ack_at, o.a_ack} !== {32'd1, 32'd41, 32'd0} || o.own_seen !== 2'b10) begin
         bad++; $display("FAIL offwin_ack b=%0d@%0d a=%0d own=%0d exp=1@41/0/2", o.b_ack, o.b_ack_at, o.a_ack, o.own_seen);
      end
      total++;
      if (b_rdata !== ref_read(2'b00, 12'h050)) begin bad++; $display("FAIL offwin_rdata got=%h exp=%h", b_rdata, ref_read(2'b00, 12'h050)); end
      ref_last_b = 1;
   endtask

   task automatic test_drop();
      obs_t o;
      wait_window(3'd4, 1'b0);
      a_req = 1; a_we = 1; a_sel = 2'b10; a_addr = 12'h0AA; a_wdata = 8'hEE;
      wait_window(3'd6, 1'b0);
      a_req = 0;
      observe(24, 1'b0, o);
      total++;
      if (o.vc !== 0 || o.a_ack !== 0) begin bad++; $display("FAIL drop_noaccess vc=%0d ack=%0d exp=0/0", o.vc, o.a_ack); end
   endtask

   task automatic test_write_front();
      obs_t o;
      wait_window(3'd7, 1'b0);
      a_req = 1; a_we = 1; a_sel = 2'b10; a_addr = 12'hFFF; a_wdata = 8'hC3;
      observe(20, 1'b1, o);
      total++;
      if ({o.front, o.side, o.back} !== {32'd16, 32'd0, 32'd0} || o.va_seen !== 12'hFFF || o.vd_seen !== 8'hC3) begin
         bad++; $display("FAIL wr_bus front=%0d va=%h vd=%h exp=16/fff/c3", o.front, o.va_seen, o.vd_seen);
      end
      total++;
      if ({o.vwe, o.voe, o.vdg, o.strobe_first} !== {32'd8, 32'd0, 32'd0, 32'd9}) begin
         bad++; $display("FAIL wr_strobe vwe=%0d voe=%0d vdg=%0d first=%0d exp=8/0/0/9", o.vwe, o.voe, o.vdg, o.strobe_first);
      end
      total++;
      if (o.a_ack !== 1 || a_rdata !== 8'h5A) begin bad++; $display("FAIL wr_ack ack=%0d rdata=%h exp=1/5a", o.a_ack, a_rdata); end
      ref_mem[2][12'hFFF] = 8'hC3; ref_wr[2][12'hFFF] = 1;
      ref_last_b = 0;
   endtask

   task automatic test_sel_none();
      obs_t o;
      wait_window(3'd3, 1'b0);
      rd_ovr_en = 1; rd_ovr = 8'h3C;
      a_req = 1; a_we = 0; a_sel = 2'b11; a_addr = 12'h123;
      observe(20, 1'b1, o);
      rd_ovr_en = 0;
      total++;
      if (o.side + o.back + o.front !== 0) begin bad++; $display("FAIL none_cs got=%0d exp=0", o.side + o.back + o.front); end
      total++;
      if (o.a_ack !== 1 || a_rdata !== 8'hFF) begin bad++; $display("FAIL none_rd ack=%0d rdata=%h exp=1/ff", o.a_ack, a_rdata); end
      ref_last_b = 0;
   endtask

   task automatic test_reset_mid();
      obs_t o;
      wait_window(3'd7, 1'b0);
      a_req = 1; a_we = 1; a_sel = 2'b00; a_addr = 12'h060; a_wdata = 8'h77;
      observe(12, 1'b0, o);
      total++;
      if (o.vwe !== 4) begin bad++; $display("FAIL rst_pre vwe=%0d exp=4", o.vwe); end
      reset = 1; a_req = 0;
      #1;
      total++;
      if ({VWE, SIDE_VRAM_CSn, V_C, a_ack} !== 4'b1100) begin
         bad++; $display("FAIL rst_async got=%b exp=1100", {VWE, SIDE_VRAM_CSn, V_C, a_ack});
      end
      observe(6, 1'b0, o);
      total++;
      if (o.a_ack !== 0 || o.vc !== 0) begin bad++; $display("FAIL rst_noack ack=%0d vc=%0d exp=0/0", o.a_ack, o.vc); end
      reset = 0;
      ref_last_b = 1;
      ref_mem[0][12'h060] = 8'h77; ref_wr[0][12'h060] = 1;
      wait_window(3'd0, 1'b1);
      a_req = 1; a_we = 0; a_sel = 2'b00; a_addr = 12'h070;
      b_req = 1; b_we = 0; b_sel = 2'b00; b_addr = 12'h080;
      observe(20, 1'b0, o);
      a_req = 0; b_req = 0;
      total++;
      if (o.own_seen !== 2'b01 || o.a_ack !== 1 || o.b_ack !== 0) begin
         bad++; $display("FAIL rst_tie own=%0d a=%0d b=%0d exp=1/1/0", o.own_seen, o.a_ack, o.b_ack);
      end
      total++;
      if (a_rdata !== ref_read(2'b00, 12'h070)) begin bad++; $display("FAIL rst_tie_rd got=%h exp=%h", a_rdata, ref_read(2'b00, 12'h070)); end
      ref_last_b = 0;
   endtask

   task automatic test_random();
      bit pa = 0, pb = 0, eb, ew;
      logic [11:0] ea;
      logic [7:0]  ed, er, got_rd;
      logic [1:0]  es;
      obs_t o;
      int ecs [3];
      for (int w = 0; w < 32; w++) begin
         wait_window(3'd0, 1'b1);
         if (!pa && $urandom_range(0, 1) == 1) begin
            pa = 1; a_we = 1'($urandom_range(0, 1)); a_addr = 12'h400 + 12'($urandom_range(0, 15));
            a_wdata = 8'($urandom); a_sel = 2'($urandom_range(0, 3)); a_req = 1;
         end
         if (!pb && $urandom_range(0, 1) == 1) begin
            pb = 1; b_we = 1'($urandom_range(0, 1)); b_addr = 12'h400 + 12'($urandom_range(0, 15));
            b_wdata = 8'($urandom); b_sel = 2'($urandom_range(0, 3)); b_req = 1;
         end
         if (!pa && !pb) begin
            observe(4, 1'b0, o);
            total++;
            if (o.vc !== 0) begin bad++; $display("FAIL rnd_idle w=%0d vc=%0d exp=0", w, o.vc); end
         end else begin
            eb = (pa && pb) ? !ref_last_b : pb;
            ew = eb ? b_we : a_we;   ea = eb ? b_addr : a_addr;
            ed = eb ? b_wdata : a_wdata; es = eb ? b_sel : a_sel;
            observe(20, 1'b1, o);
            got_rd = eb ? b_rdata : a_rdata;
            total++;
            if (o.own_seen !== (eb ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rnd_owner w=%0d got=%0d exp=%0d", w, o.own_seen, eb ? 2 : 1); end
            total++;
            if ((eb ? {o.b_ack, o.b_ack_at, o.a_ack} : {o.a_ack, o.a_ack_at, o.b_ack}) !== {32'd1, 32'd17, 32'd0}) begin
               bad++; $display("FAIL rnd_ack w=%0d a=%0d@%0d b=%0d@%0d exp_one_at_17", w, o.a_ack, o.a_ack_at, o.b_ack, o.b_ack_at);
            end
            for (int l = 0; l < 3; l++) ecs[l] = (int'(es) == l) ? 16 : 0;
            total++;
            if ({o.side, o.back, o.front} !== {ecs[0], ecs[1], ecs[2]} || o.va_seen !== ea) begin
               bad++; $display("FAIL rnd_cs w=%0d cs=%0d/%0d/%0d va=%h exp_sel=%0d va=%h", w, o.side, o.back, o.front, o.va_seen, es, ea);
            end
            total++;
            if (ew) begin
               if (o.vd_seen !== ed || o.vwe !== 8) begin bad++; $display("FAIL rnd_wr w=%0d vd=%h vwe=%0d exp=%h/8", w, o.vd_seen, o.vwe, ed); end
               if (es != 2'b11) begin ref_mem[es][ea] = ed; ref_wr[es][ea] = 1; end
            end else begin
               er = ref_read(es, ea);
               if (got_rd !== er || o.voe !== 8) begin bad++; $display("FAIL rnd_rd w=%0d got=%h exp=%h voe=%0d", w, got_rd, er, o.voe); end
            end
            ref_last_b = eb;
            if (eb) pb = 0; else pa = 0;
         end
      end
      a_req = 0; b_req = 0;
   endtask

   task automatic test_invariants();
      total++;
      if (inv_viol !== 0) begin bad++; $display("FAIL bus_invariants got=%0d exp=0", inv_viol); end
   endtask

   initial begin
      test_reset();
      test_tie();
      test_read_back1();
      test_off_window();
      test_drop();
      test_write_front();
      test_sel_none();
      test_reset_mid();
      test_random();
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alphamission_vram_arbiter.md
Name: alphamission_vram_arbiter

Overview:
Time-slot arbiter for the shared video bus between CPU A, CPU B and the layer video fetch. The bus comprises the VA address, the VD write/read data, the layer chip selects, the V/C selector and the VWE/VOE/VDG strobes. It opens CPU access windows at fixed H[2:0] phases of the 6.7 MHz pixel enable and never touches the video-owned phases. It grants one CPU per window, round-robin on contention, and runs a SETUP/STROBE/DONE sequence. It sits between the CPU A/B bus logic and the Side/Back1/Front layer blocks.

Parameters:
SLOT_A, 3'd3, H[2:0] value at which the first CPU window opens
SLOT_B, 3'd7, H[2:0] value at which the second CPU window opens

Ports:
clk  in  1  system clock, 53.6 MHz
reset  in  1  asynchronous, active-high
cen  in  1  pixel clock enable, 6.7 MHz; all state advances only on cen except DONE->IDLE
h_phase  in  3  H[2:0] from the video timing block
a_req, b_req  in  1  access request; held high until the matching ack
a_we, b_we  in  1  1 = write, 0 = read
a_addr, b_addr  in  12  VA address
a_wdata, b_wdata  in  8  write data
a_sel, b_sel  in  2  target: 00 side, 01 back1, 10 front, 11 none
a_ack, b_ack  out  1  one-clk completion pulse
a_rdata, b_rdata  out  8  read data, valid from ack onward, held until the next own read
vram_rdata  in  8  muxed layer read bus; reads 8'hFF when nothing is selected
VA  out  12  bus address
VD_in  out  8  write data to the layers
SIDE_VRAM_CSn, BACK1_VRAM_CSn, FRONT_VIDEO_CSn  out  1  active-low chip selects
V_C  out  1  1 = CPU owns the SRAM address, 0 = video
VWE, VOE, VDG  out  1  active-low write strobe, output enable, read-data gate
owner  out  2  00 none, 01 A, 10 B (debug)

Behaviour:
- Reset values: all CSn/VWE/VOE/VDG = 1; V_C = 0; VA = 0; VD_in = 0; acks = 0; a_rdata = b_rdata = 8'hFF; owner = 00; state = IDLE; last_grant = B, so A wins the first tie.
- Window: a window is open when cen = 1 and h_phase is SLOT_A or SLOT_B. Requests outside a window wait; no grant occurs off-window.
- IDLE: arbitration happens only on the window cen.
  - Only one requester high: that requester is granted.
  - Both high: the requester not equal to last_grant is granted.
  - On grant, latch we/addr/wdata/sel, update last_grant, set owner, go to SETUP.
- SETUP (one cen period):
  - V_C = 1, VA = latched addr.
  - CSn of the selected layer = 0; no CSn if sel = 11.
  - VD_in = wdata on writes.
  - Advance to STROBE on the next cen.
- STROBE (one cen period):
  - Write: VWE = 0.
  - Read: VOE = 0 and VDG = 0.
  - On the closing cen, capture vram_rdata into the owner's rdata (reads only; sel = 11 captures 8'hFF), release VWE/VOE/VDG, and go to DONE.
- DONE (exactly one clk):
  - Owner's ack = 1.
  - CSn = 1, V_C = 0, owner = 00.
  - Next clk: IDLE.
- Latency with defaults, grant at the phase-3 cen: SETUP spans phase 4, STROBE spans phase 5, ack fires in the clk after the phase-6-start cen. Bus is idle before phase 7, so back-to-back windows never overlap.
- Requester may drop req in the ack clk. If req is still high at the next window, it counts as a new access.
- A req dropped before grant causes no access. A req dropped after grant is ignored; the access completes and is acked.
- A requester whose req stays high while the other is also requesting is served at most every other window (no starvation).
- Asynchronous reset at any point returns all outputs to reset values immediately. An in-flight access is abandoned with no ack.
- Only one CSn is ever low at a time. VWE and VOE are never low simultaneously. VWE/VOE/VDG are low only while V_C = 1.

Test Plan:
1. A read back1: a_req, a_sel = 01, a_addr = 12'h234, layer returns 8'h5A -> BACK1_VRAM_CSn low for 2 cen, VOE/VDG low in STROBE only, a_ack one clk, a_rdata = 8'h5A, b_ack stays 0.
2. Tie: a_req and b_req both held across 4 windows (both writes to side) -> grant order A, B, A, B; owner matches; each ack one clk; VD_in = the granted requester's wdata during SETUP/STROBE.
3. Off-window request: b_req rises at h_phase = 4 -> no bus activity until the h_phase = 7 cen; SETUP begins at phase 0.
4. Write to front, sel = 10, addr 12'hFFF, data 8'hC3 -> VA = 12'hFFF, FRONT_VIDEO_CSn low, VWE low exactly one cen period, VOE/VDG stay 1.
5. sel = 11 read -> no CSn asserted, a_rdata = 8'hFF, a_ack still pulses.
6. Reset asserted mid-STROBE of a write -> VWE/CSn = 1 and V_C = 0 within the same clk, no ack. After release, the first tie goes to A.
